// File: rtl/alu8_pkg.sv
// rtl/alu8_pkg.sv - shared opcodes, FSM states and flag helper for the 8-bit ALU sequencer
package alu8_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int ITER_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_t;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic negative;
    logic error;
  } flags_t;

  function automatic flags_t make_flags(input logic [7:0] res, input logic ovf, input logic dz);
    flags_t f;
    f.overflow = ovf;
    f.zero     = (res == 8'h00);
    f.negative = res[7];
    f.error    = dz;
    return f;
  endfunction

endpackage

// File: rtl/alu8_muldiv_iter.sv
// rtl/alu8_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module alu8_muldiv_iter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic       is_div,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] res_next,
  output logic       ovf_next
);

  logic       div_q;
  logic [7:0] m_q;   // multiplicand (mult) or divisor (div)
  logic [7:0] hi_q;  // product high half or partial remainder
  logic [7:0] lo_q;  // multiplier shifting out / quotient shifting in

  logic [8:0] add9;
  logic [7:0] mul_hi, mul_lo;
  logic [8:0] shl9;
  logic [7:0] dif8;
  logic       fits;
  logic [7:0] div_hi, div_lo;
  logic [7:0] hi_nx, lo_nx;

  always_comb begin
    add9   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 9'd0);
    mul_hi = add9[8:1];
    mul_lo = {add9[0], lo_q[7:1]};

    // When the divisor fits, the true difference is below 256 so 8 bits suffice.
    shl9   = {hi_q, lo_q[7]};
    fits   = (shl9 >= {1'b0, m_q});
    dif8   = shl9[7:0] - m_q;
    div_hi = fits ? dif8 : shl9[7:0];
    div_lo = {lo_q[6:0], fits};

    hi_nx    = div_q ? div_hi : mul_hi;
    lo_nx    = div_q ? div_lo : mul_lo;
    res_next = lo_nx;
    ovf_next = div_q ? 1'b0 : (mul_hi != 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      m_q   <= 8'h00;
      hi_q  <= 8'h00;
      lo_q  <= 8'h00;
    end else if (load) begin
      div_q <= is_div;
      m_q   <= is_div ? b : a;
      hi_q  <= 8'h00;
      lo_q  <= is_div ? a : b;
    end else if (step) begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
    end
  end

endmodule

// File: rtl/alu_seq8.sv
// rtl/alu_seq8.sv - sequencing controller for the 8-bit ALU: single-cycle ops plus iterative mult/div
module alu_seq8
  import alu8_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] Op,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Overflow,
  output logic       Zero,
  output logic       Negative,
  output logic       Error
);

  state_t            state;
  logic [ITER_W-1:0] count;
  logic              exec_ph;
  logic [7:0]        a_q, b_q;
  logic [2:0]        op_q;
  flags_t            flags_q;

  logic       accept;
  logic       go_iter;
  logic [7:0] md_res;
  logic       md_ovf;

  logic [8:0] sum9;
  logic [7:0] exec_res;
  logic       exec_ovf;
  logic       exec_dz;

  assign accept  = Start && (state == S_IDLE || state == S_DONE);
  assign go_iter = (Op == OP_MUL) || (Op == OP_DIV && B != 8'h00);

  alu8_muldiv_iter u_muldiv (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (accept),
    .step     (state == S_ITER),
    .is_div   (Op == OP_DIV),
    .a        (A),
    .b        (B),
    .res_next (md_res),
    .ovf_next (md_ovf)
  );

  // Only non-iterative ops reach EXEC; divide here always means divide by zero.
  always_comb begin
    sum9     = {1'b0, a_q} + {1'b0, b_q};
    exec_res = 8'h00;
    exec_ovf = 1'b0;
    exec_dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = sum9[7:0];
        exec_ovf = sum9[8];
      end
      OP_SUB: begin
        exec_res = a_q - b_q;
        exec_ovf = (a_q < b_q);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_NOT: exec_res = ~a_q;
      OP_DIV: exec_dz  = 1'b1;
      default: exec_res = 8'h00;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      count   <= '0;
      exec_ph <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= OP_ADD;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= 8'h00;
      flags_q <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= Op;
            count   <= '0;
            exec_ph <= 1'b0;
            Busy    <= 1'b1;
            state   <= go_iter ? S_ITER : S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end
        // EXEC spends two cycles so simple ops complete two edges after Start.
        S_EXEC: begin
          if (!exec_ph) begin
            exec_ph <= 1'b1;
          end else begin
            exec_ph <= 1'b0;
            Result  <= exec_res;
            flags_q <= make_flags(exec_res, exec_ovf, exec_dz);
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_ITER: begin
          count <= count + 1'b1;
          if (count == ITER_W'(ITER - 1)) begin
            Result  <= md_res;
            flags_q <= make_flags(md_res, md_ovf, 1'b0);
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Overflow = flags_q.overflow;
  assign Zero     = flags_q.zero;
  assign Negative = flags_q.negative;
  assign Error    = flags_q.error;

endmodule
